// File: rtl/dm_pkg.sv
// Shared types and helpers for the data-memory responder.
package dm_pkg;
  localparam int DM_WORD_W = 32;

  typedef enum logic [1:0] {CLEAR, IDLE, WAIT, RESP} dm_state_t;

  function automatic logic [DM_WORD_W-1:0] merge_be(input logic [DM_WORD_W-1:0] old_w,
                                                    input logic [DM_WORD_W-1:0] new_w,
                                                    input logic [3:0]           be);
    logic [DM_WORD_W-1:0] m;
    for (int i = 0; i < 4; i++)
      m[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    return m;
  endfunction
endpackage

// File: rtl/dm_if.sv
// Load/store request/response channel, plus the store-trace observation signals.
interface dm_if;
  import dm_pkg::*;
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [DM_WORD_W-1:0] req_addr;
  logic [3:0]           req_be;
  logic [DM_WORD_W-1:0] req_wdata;
  logic [DM_WORD_W-1:0] req_pc;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [DM_WORD_W-1:0] rsp_rdata;
  logic                 rsp_err;
  // one-cycle pulse in the first RESP cycle of a committed store
  logic                 trace_valid;
  logic [DM_WORD_W-1:0] trace_pc;
  logic [DM_WORD_W-1:0] trace_addr;
  logic [DM_WORD_W-1:0] trace_data;

  modport master (output req_valid, req_we, req_addr, req_be, req_wdata, req_pc, rsp_ready,
                  input  req_ready, rsp_valid, rsp_rdata, rsp_err,
                         trace_valid, trace_pc, trace_addr, trace_data);
  modport slave  (input  req_valid, req_we, req_addr, req_be, req_wdata, req_pc, rsp_ready,
                  output req_ready, rsp_valid, rsp_rdata, rsp_err,
                         trace_valid, trace_pc, trace_addr, trace_data);
endinterface

// File: rtl/dm_array.sv
// Single-port word array with byte-lane writes and a registered, write-first read.
module dm_array
  import dm_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic                 re,
  input  logic [AW-1:0]        idx,
  input  logic [3:0]           be,
  input  logic [DM_WORD_W-1:0] wdata,
  output logic [DM_WORD_W-1:0] rdata
);
  logic [DM_WORD_W-1:0] mem [DEPTH];
  logic [DM_WORD_W-1:0] merged;

  assign merged = merge_be(mem[idx], wdata, be);

  // rdata only moves on a read, so it holds through a stalled response
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= merged;
    if (re) rdata <= we ? merged : mem[idx];
  end
endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: one outstanding request, programmable wait states, registered response.
//   state | meaning
//   CLEAR | zeroing the array after reset, one word per cycle
//   IDLE  | ready for a request
//   WAIT  | counting down wait states before the access
//   RESP  | response presented until rsp_ready
module dm_responder
  import dm_pkg::*;
#(
  parameter int          DEPTH_WORDS  = 3072,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          WAIT_CYCLES  = 1,
  parameter bit          CLR_ON_RESET = 1'b1
) (
  input  logic clk,
  input  logic reset,
  dm_if.slave  bus
);
  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN      = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  WAIT_LD   = 4'(WAIT_CYCLES);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH_WORDS - 1);
  localparam dm_state_t   RST_STATE = CLR_ON_RESET ? CLEAR : IDLE;

  dm_state_t            state;
  logic [3:0]           cnt;
  logic [AW-1:0]        clr_ptr;
  logic                 we_q;
  logic [DM_WORD_W-1:0] addr_q, wdata_q, pc_q;
  logic [3:0]           be_q;
  logic                 req_ready_q, rsp_valid_q, rsp_err_q, rsp_load_q, trace_valid_q;

  logic                 accept, access, a_we, a_err;
  logic [DM_WORD_W-1:0] a_addr, a_wdata;
  logic [3:0]           a_be;
  logic [32:0]          offs;
  logic                 arr_we, arr_re;
  logic [AW-1:0]        arr_idx;
  logic [3:0]           arr_be;
  logic [DM_WORD_W-1:0] arr_wdata, arr_rdata;

  assign accept  = (state == IDLE) && bus.req_valid && req_ready_q;
  assign access  = (accept && WAIT_LD == 4'd0) || (state == WAIT && cnt == 4'd1);
  assign a_we    = (state == IDLE) ? bus.req_we    : we_q;
  assign a_addr  = (state == IDLE) ? bus.req_addr  : addr_q;
  assign a_be    = (state == IDLE) ? bus.req_be    : be_q;
  assign a_wdata = (state == IDLE) ? bus.req_wdata : wdata_q;

  // 33-bit offset: bit 32 flags an address below BASE_ADDR without wrapping
  assign offs  = {1'b0, a_addr} - {1'b0, BASE_ADDR};
  assign a_err = (a_addr[1:0] != 2'b00) || offs[32] || (offs[31:0] >= SPAN);

  assign arr_we    = (state == CLEAR) || (access && a_we && !a_err);
  assign arr_re    = access && !a_err;
  assign arr_idx   = (state == CLEAR) ? clr_ptr : offs[AW+1:2];
  assign arr_be    = (state == CLEAR) ? 4'hF : a_be;
  assign arr_wdata = (state == CLEAR) ? '0 : a_wdata;

  dm_array #(.DEPTH(DEPTH_WORDS), .AW(AW)) u_array (
    .clk   (clk),
    .we    (arr_we),
    .re    (arr_re),
    .idx   (arr_idx),
    .be    (arr_be),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= RST_STATE;
      cnt           <= '0;
      clr_ptr       <= '0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      be_q          <= '0;
      wdata_q       <= '0;
      pc_q          <= '0;
      req_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_load_q    <= 1'b0;
      trace_valid_q <= 1'b0;
    end else begin
      trace_valid_q <= 1'b0;
      case (state)
        CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == LAST) begin
            state       <= IDLE;
            req_ready_q <= 1'b1;
          end
        end
        IDLE: begin
          if (accept) begin
            we_q        <= bus.req_we;
            addr_q      <= bus.req_addr;
            be_q        <= bus.req_be;
            wdata_q     <= bus.req_wdata;
            pc_q        <= bus.req_pc;
            cnt         <= WAIT_LD;
            req_ready_q <= 1'b0;
            if (WAIT_LD != 4'd0) state <= WAIT;
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        WAIT: cnt <= cnt - 1'b1;
        RESP: begin
          if (bus.rsp_ready) begin
            state       <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_load_q  <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: state <= RST_STATE;
      endcase
      // the access overrides whatever the case chose for the next state
      if (access) begin
        state         <= RESP;
        req_ready_q   <= 1'b0;
        rsp_valid_q   <= 1'b1;
        rsp_err_q     <= a_err;
        rsp_load_q    <= !a_we && !a_err;
        trace_valid_q <= a_we && !a_err;
      end
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.rsp_rdata   = rsp_load_q ? arr_rdata : '0;
  assign bus.trace_valid = trace_valid_q;
  assign bus.trace_pc    = pc_q;
  assign bus.trace_addr  = addr_q;
  assign bus.trace_data  = arr_rdata;
endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: table-driven transactions with a scoreboard queue.
module tb_dm_responder;
  import dm_pkg::*;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] pc;
    int          hold;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        exp_tv;
    logic [31:0] exp_tdata;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        tv;
    logic [31:0] tdata;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rst_b, sel;
  logic        req_valid, req_we, rsp_ready;
  logic [31:0] req_addr, req_wdata, req_pc;
  logic [3:0]  req_be;

  dm_if bus_a();
  dm_if bus_b();

  assign bus_a.req_valid = req_valid & ~sel;
  assign bus_a.rsp_ready = rsp_ready & ~sel;
  assign bus_a.req_we    = req_we;
  assign bus_a.req_addr  = req_addr;
  assign bus_a.req_be    = req_be;
  assign bus_a.req_wdata = req_wdata;
  assign bus_a.req_pc    = req_pc;
  assign bus_b.req_valid = req_valid & sel;
  assign bus_b.rsp_ready = rsp_ready & sel;
  assign bus_b.req_we    = req_we;
  assign bus_b.req_addr  = req_addr;
  assign bus_b.req_be    = req_be;
  assign bus_b.req_wdata = req_wdata;
  assign bus_b.req_pc    = req_pc;

  dm_responder #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0), .WAIT_CYCLES(2), .CLR_ON_RESET(1'b1))
    dut_a (.clk(clk), .reset(rst_a), .bus(bus_a));
  dm_responder #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0), .WAIT_CYCLES(2), .CLR_ON_RESET(1'b0))
    dut_b (.clk(clk), .reset(rst_b), .bus(bus_b));

  logic        rdy, rv, err, tv;
  logic [31:0] rdata, tdata, tpc, taddr;
  assign rdy   = sel ? bus_b.req_ready   : bus_a.req_ready;
  assign rv    = sel ? bus_b.rsp_valid   : bus_a.rsp_valid;
  assign err   = sel ? bus_b.rsp_err     : bus_a.rsp_err;
  assign rdata = sel ? bus_b.rsp_rdata   : bus_a.rsp_rdata;
  assign tv    = sel ? bus_b.trace_valid : bus_a.trace_valid;
  assign tdata = sel ? bus_b.trace_data  : bus_a.trace_data;
  assign tpc   = sel ? bus_b.trace_pc    : bus_a.trace_pc;
  assign taddr = sel ? bus_b.trace_addr  : bus_a.trace_addr;

  always @(negedge clk)
    if (tv === 1'b1) $display("@%08h: *%08h <= %08h", tpc, taddr, tdata);

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sbq[$];
  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [3:0] be,
                              input logic [31:0] wdata, input logic [31:0] pc, input int hold,
                              input logic [31:0] exp_rdata, input logic exp_err,
                              input logic exp_tv, input logic [31:0] exp_tdata);
    vec_t v;
    v.we = we; v.addr = addr; v.be = be; v.wdata = wdata; v.pc = pc; v.hold = hold;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_tv = exp_tv; v.exp_tdata = exp_tdata;
    return v;
  endfunction

  // called at a negedge; returns at the negedge right after the accepting edge
  task automatic issue(input vec_t v);
    exp_t e;
    int   t = 0;
    req_we = v.we; req_addr = v.addr; req_be = v.be; req_wdata = v.wdata; req_pc = v.pc;
    req_valid = 1'b1;
    e.rdata = v.exp_rdata; e.err = v.exp_err; e.tv = v.exp_tv; e.tdata = v.exp_tdata;
    sbq.push_back(e);
    while (rdy !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("accept_ready", 32'(rdy), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic complete(input int hold);
    exp_t e;
    int   lat = 0;
    while (rv !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'd2);
    if (sbq.size() == 0) begin
      chk("scoreboard_empty", 32'(sbq.size()), 32'd1);
      return;
    end
    e = sbq.pop_front();
    chk("rsp_rdata", rdata, e.rdata);
    chk("rsp_err", 32'(err), 32'(e.err));
    chk("trace_valid", 32'(tv), 32'(e.tv));
    if (e.tv) chk("trace_data", tdata, e.tdata);
    chk("resp_req_ready", 32'(rdy), 32'd0);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("hold_valid", 32'(rv), 32'd1);
      chk("hold_rdata", rdata, e.rdata);
      chk("hold_err", 32'(err), 32'(e.err));
      chk("hold_ready", 32'(rdy), 32'd0);
      if (k == 0) chk("trace_pulse", 32'(tv), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("release_valid", 32'(rv), 32'd0);
    chk("release_ready", 32'(rdy), 32'd1);
    chk("release_rdata", rdata, 32'd0);
    chk("release_err", 32'(err), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    exp_t dropped;
    vecs[0]  = mk(1'b0, 32'h3C, 4'h0, 32'h0,        32'h3000, 0, 32'h0,        1'b0, 1'b0, 32'h0);
    vecs[1]  = mk(1'b1, 32'h08, 4'hF, 32'h12345678, 32'h3004, 0, 32'h0,        1'b0, 1'b1, 32'h12345678);
    vecs[2]  = mk(1'b0, 32'h08, 4'h0, 32'h0,        32'h3008, 0, 32'h12345678, 1'b0, 1'b0, 32'h0);
    vecs[3]  = mk(1'b1, 32'h08, 4'h5, 32'hAABBCCDD, 32'h300C, 0, 32'h0,        1'b0, 1'b1, 32'h12BB56DD);
    vecs[4]  = mk(1'b0, 32'h08, 4'h0, 32'h0,        32'h3010, 5, 32'h12BB56DD, 1'b0, 1'b0, 32'h0);
    vecs[5]  = mk(1'b0, 32'h06, 4'h0, 32'h0,        32'h3014, 0, 32'h0,        1'b1, 1'b0, 32'h0);
    vecs[6]  = mk(1'b1, 32'h40, 4'hF, 32'hFFFFFFFF, 32'h3018, 3, 32'h0,        1'b1, 1'b0, 32'h0);
    vecs[7]  = mk(1'b0, 32'h00, 4'h0, 32'h0,        32'h301C, 0, 32'h0,        1'b0, 1'b0, 32'h0);
    vecs[8]  = mk(1'b1, 32'h0C, 4'h0, 32'h55555555, 32'h3020, 0, 32'h0,        1'b0, 1'b1, 32'h0);
    vecs[9]  = mk(1'b0, 32'h0C, 4'h0, 32'h0,        32'h3024, 0, 32'h0,        1'b0, 1'b0, 32'h0);
    vecs[10] = mk(1'b1, 32'h3C, 4'hF, 32'hCAFEF00D, 32'h3028, 0, 32'h0,        1'b0, 1'b1, 32'hCAFEF00D);
    vecs[11] = mk(1'b0, 32'h3C, 4'h0, 32'h0,        32'h302C, 0, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0);
    vecs[12] = mk(1'b0, 32'hFFFFFFFC, 4'h0, 32'h0,  32'h3030, 0, 32'h0,        1'b1, 1'b0, 32'h0);
    vecs[13] = mk(1'b0, 32'h08, 4'h0, 32'h0,        32'h3034, 0, 32'h12BB56DD, 1'b0, 1'b0, 32'h0);

    sel = 1'b0; rst_a = 1'b0; rst_b = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_be = '0; req_wdata = '0; req_pc = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ready", 32'(rdy), 32'd0);
    chk("reset_valid", 32'(rv), 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_err", 32'(err), 32'd0);

    rst_a = 1'b1;
    n = 0;
    while (rdy !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("clear_cycles", 32'(n), 32'd16);

    for (int i = 0; i < 14; i++) begin
      issue(vecs[i]);
      complete(vecs[i].hold);
    end

    // reset during WAIT drops the pending store (no clear on reset here)
    sel = 1'b1;
    @(negedge clk);
    rst_b = 1'b1;
    n = 0;
    while (rdy !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("b_ready_after_reset", 32'(n), 32'd1);
    issue(mk(1'b1, 32'h10, 4'hF, 32'h0BADF00D, 32'h4000, 0, 32'h0, 1'b0, 1'b1, 32'h0BADF00D));
    complete(0);
    issue(mk(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h4004, 0, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF));
    @(negedge clk);
    rst_b = 1'b0;
    #1;
    chk("midreset_ready", 32'(rdy), 32'd0);
    chk("midreset_valid", 32'(rv), 32'd0);
    chk("midreset_rdata", rdata, 32'd0);
    chk("midreset_err", 32'(err), 32'd0);
    chk("midreset_trace", 32'(tv), 32'd0);
    dropped = sbq.pop_front();
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    n = 0;
    while (rdy !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("b_ready_after_midreset", 32'(n), 32'd1);
    issue(mk(1'b0, 32'h10, 4'h0, 32'h0, 32'h4008, 2, 32'h0BADF00D, 1'b0, 1'b0, 32'h0));
    complete(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
